// File: rtl/chf_pll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chf_pll_pkg
// Brief    : Shared types, register map and write-table lookup for the PLL
//            reconfiguration controller.
// Revision : 1.0 - initial release
// ============================================================================
package chf_pll_pkg;

  // Controller phases.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    EXTEND    = 2'd2,
    WAIT_LOCK = 2'd3
  } state_e;

  // Reconfiguration IP register addresses.
  localparam logic [5:0] A_MODE  = 6'h00;
  localparam logic [5:0] A_N     = 6'h03;
  localparam logic [5:0] A_M     = 6'h04;
  localparam logic [5:0] A_C0    = 6'h05;
  localparam logic [5:0] A_MFRAC = 6'h07;
  localparam logic [5:0] A_START = 6'h02;

  // Register payloads. Mode 0 selects waitrequest mode on the reconfig IP.
  localparam logic [31:0] D_MODE       = 32'h0000_0000;
  localparam logic [31:0] D_N          = 32'h0001_0000;
  localparam logic [31:0] D_M          = 32'h0000_0404;
  localparam logic [31:0] D_C0_NTSC    = 32'h0000_0505;
  localparam logic [31:0] D_C0_PAL     = 32'h0002_0504;
  localparam logic [31:0] D_MFRAC_NTSC = 32'h9745_BF27;
  localparam logic [31:0] D_MFRAC_PAL  = 32'hA3D7_09E8;
  localparam logic [31:0] D_START      = 32'h0000_0000;

  // Index of the start-reconfig write, the final entry of the sequence.
  localparam logic [2:0] LAST_IDX = 3'd5;

  // One Avalon-MM write: address plus data.
  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } mgmt_word_t;

  // Six-entry reconfiguration table; pal selects the PAL clock plan.
  function automatic mgmt_word_t reconfig_entry(input logic [2:0] idx,
                                                input logic       pal);
    mgmt_word_t w;
    w.addr = A_MODE;
    w.data = D_MODE;
    case (idx)
      3'd0: begin w.addr = A_MODE;  w.data = D_MODE;  end
      3'd1: begin w.addr = A_N;     w.data = D_N;     end
      3'd2: begin w.addr = A_M;     w.data = D_M;     end
      3'd3: begin w.addr = A_C0;    w.data = pal ? D_C0_PAL : D_C0_NTSC;       end
      3'd4: begin w.addr = A_MFRAC; w.data = pal ? D_MFRAC_PAL : D_MFRAC_NTSC; end
      3'd5: begin w.addr = A_START; w.data = D_START; end
      default: begin w.addr = A_MODE; w.data = D_MODE; end
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chf_sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : chf_sync_bit
// Brief    : Single-bit multi-flop synchroniser with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module chf_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain, oldest at the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/chf_pll_reconfig.sv
`default_nettype none
// ============================================================================
// Module   : chf_pll_reconfig
// Brief    : Reprograms the system PLL over Avalon-MM whenever the NTSC/PAL
//            selection changes and holds the console core in reset until the
//            PLL relocks (or the lock wait times out).
// Revision : 1.0 - initial release
// ============================================================================
module chf_pll_reconfig
  import chf_pll_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_EXTEND = 16,
  parameter int LOCK_TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_pal,
  input  logic        io_pll_locked,
  input  logic        io_mgmt_waitrequest,
  output logic        io_mgmt_write,
  output logic [5:0]  io_mgmt_address,
  output logic [31:0] io_mgmt_writedata,
  output logic        io_tv_reset,
  output logic        io_busy,
  output logic        io_cur_pal,
  output logic        io_timeout
);

  // Counters hold at most PARAM-1, so $clog2 bits never wrap.
  localparam int EXT_W = (RESET_EXTEND > 1) ? $clog2(RESET_EXTEND) : 1;
  localparam int TO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [EXT_W-1:0] EXT_INIT = EXT_W'(RESET_EXTEND - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  logic pal_s;
  logic lock_s;

  state_e           state_q,    state_d;
  logic [2:0]       idx_q,      idx_d;
  logic             target_q,   target_d;
  logic             cur_pal_q,  cur_pal_d;
  logic             tv_reset_q, tv_reset_d;
  logic             timeout_q,  timeout_d;
  logic [EXT_W-1:0] ext_cnt_q,  ext_cnt_d;
  logic [TO_W-1:0]  to_cnt_q,   to_cnt_d;

  mgmt_word_t entry;

  chf_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_pal (
    .clk   (clk),
    .reset (reset),
    .d_i   (io_pal),
    .q_o   (pal_s)
  );

  chf_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .reset (reset),
    .d_i   (io_pll_locked),
    .q_o   (lock_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      target_q   <= 1'b0;
      cur_pal_q  <= 1'b0;
      tv_reset_q <= 1'b0;
      timeout_q  <= 1'b0;
      ext_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      target_q   <= target_d;
      cur_pal_q  <= cur_pal_d;
      tv_reset_q <= tv_reset_d;
      timeout_q  <= timeout_d;
      ext_cnt_q  <= ext_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Next-state logic: program, extend reset, then wait for lock.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    target_d   = target_q;
    cur_pal_d  = cur_pal_q;
    tv_reset_d = tv_reset_q;
    timeout_d  = timeout_q;
    ext_cnt_d  = ext_cnt_q;
    to_cnt_d   = to_cnt_q;

    case (state_q)
      IDLE: begin
        // A mismatch seen here (including one that arose mid-sequence)
        // starts a fresh sequence; the core reset is raised or kept high.
        if (pal_s != cur_pal_q) begin
          state_d    = WRITE;
          idx_d      = 3'd0;
          target_d   = pal_s;
          tv_reset_d = 1'b1;
          timeout_d  = 1'b0;
        end
      end
      WRITE: begin
        if (!io_mgmt_waitrequest) begin
          if (idx_q == LAST_IDX) begin
            cur_pal_d = target_q;
            state_d   = EXTEND;
            ext_cnt_d = EXT_INIT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      EXTEND: begin
        if (ext_cnt_q == '0) begin
          state_d  = WAIT_LOCK;
          to_cnt_d = '0;
        end else begin
          ext_cnt_d = ext_cnt_q - 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Release the core only if no follow-up sequence is pending, so
        // the reset stays continuous across back-to-back sequences.
        if (lock_s) begin
          state_d    = IDLE;
          tv_reset_d = (pal_s != cur_pal_q);
        end else if (to_cnt_q == TO_LAST) begin
          state_d    = IDLE;
          timeout_d  = 1'b1;
          tv_reset_d = (pal_s != cur_pal_q);
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign entry             = reconfig_entry(idx_q, target_q);
  assign io_mgmt_write     = (state_q == WRITE);
  assign io_mgmt_address   = io_mgmt_write ? entry.addr : 6'h00;
  assign io_mgmt_writedata = io_mgmt_write ? entry.data : 32'h0000_0000;
  assign io_tv_reset       = tv_reset_q;
  assign io_busy           = (state_q != IDLE);
  assign io_cur_pal        = cur_pal_q;
  assign io_timeout        = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_chf_pll_reconfig.sv
`default_nettype none
// ============================================================================
// Module   : tb_chf_pll_reconfig
// Brief    : Self-checking bench for chf_pll_reconfig: table-driven scenarios,
//            hand-written corner sequences and randomized runs scored against
//            a transaction-level model of the write sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chf_pll_reconfig;

  localparam int SYNC = 2;
  localparam int RE   = 16;
  localparam int LT   = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_pal;
  logic        io_pll_locked;
  logic        io_mgmt_waitrequest;
  logic        io_mgmt_write;
  logic [5:0]  io_mgmt_address;
  logic [31:0] io_mgmt_writedata;
  logic        io_tv_reset;
  logic        io_busy;
  logic        io_cur_pal;
  logic        io_timeout;

  chf_pll_reconfig #(
    .SYNC_STAGES  (SYNC),
    .RESET_EXTEND (RE),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .io_pal              (io_pal),
    .io_pll_locked       (io_pll_locked),
    .io_mgmt_waitrequest (io_mgmt_waitrequest),
    .io_mgmt_write       (io_mgmt_write),
    .io_mgmt_address     (io_mgmt_address),
    .io_mgmt_writedata   (io_mgmt_writedata),
    .io_tv_reset         (io_tv_reset),
    .io_busy             (io_busy),
    .io_cur_pal          (io_cur_pal),
    .io_timeout          (io_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } xfer_t;

  xfer_t cap_q[$];
  xfer_t exp_q[$];

  // Run observations.
  int cyc, last_xfer, fall_cyc, to_cyc, gap_err, stab_err, held_cyc;
  bit to_seen, rst_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: the six transfers a sequence for standard t must produce.
  function automatic void add_seq(input logic t);
    exp_q.push_back({6'h00, 32'h0000_0000});
    exp_q.push_back({6'h03, 32'h0001_0000});
    exp_q.push_back({6'h04, 32'h0000_0404});
    exp_q.push_back({6'h05, t ? 32'h0002_0504 : 32'h0000_0505});
    exp_q.push_back({6'h07, t ? 32'hA3D7_09E8 : 32'h9745_BF27});
    exp_q.push_back({6'h02, 32'h0000_0000});
  endfunction

  task automatic cmp_xfers(input string tag);
    chk({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write"},   64'(io_mgmt_write),     64'd0);
    chk({tag, "_addr"},    64'(io_mgmt_address),   64'd0);
    chk({tag, "_data"},    64'(io_mgmt_writedata), 64'd0);
    chk({tag, "_tvreset"}, 64'(io_tv_reset),       64'd0);
    chk({tag, "_busy"},    64'(io_busy),           64'd0);
    chk({tag, "_curpal"},  64'(io_cur_pal),        64'd0);
    chk({tag, "_timeout"}, 64'(io_timeout),        64'd0);
  endtask

  // Acts as the Avalon slave until the controller is idle with the core
  // released. Waitrequest is decided at each negedge for the next posedge.
  task automatic run(input int stall_idx, input int stall_len, input int toggle_at,
                     input int reset_at, input bit rnd);
    int k;
    int stalls = 0;
    int consec = 0;
    int budget = 2000 + LT;
    bit started = 0;
    bit toggled = 0;
    bit prev_stall = 0;
    bit wr;
    logic [5:0]  pa = '0;
    logic [31:0] pd = '0;
    cap_q.delete();
    cyc = 0; last_xfer = 0; fall_cyc = 0; to_cyc = 0;
    gap_err = 0; stab_err = 0; held_cyc = 0; to_seen = 0; rst_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > budget) begin
        checks++;
        errors++;
        $display("FAIL run_budget actual=%0d cycles required=idle before %0d", cyc, budget);
        break;
      end
      if (io_busy) started = 1;
      if (io_timeout && !to_seen) begin
        to_seen = 1;
        to_cyc  = cyc;
      end
      if (started && !io_busy && !io_tv_reset) begin
        fall_cyc = cyc;
        break;
      end
      if (io_busy && !io_tv_reset) gap_err++;
      if (prev_stall && (!io_mgmt_write || io_mgmt_address !== pa || io_mgmt_writedata !== pd))
        stab_err++;
      wr = 0;
      if (io_mgmt_write) begin
        k = cap_q.size();
        if (k == reset_at) begin
          reset = 1'b1;
          io_mgmt_waitrequest = 1'b0;
          rst_done = 1;
          break;
        end
        if (k == stall_idx) held_cyc++;
        if (rnd) wr = (consec < 3) && ($urandom_range(0, 2) == 0);
        else     wr = (k == stall_idx) && (stalls < stall_len);
        if (wr) begin
          stalls++;
          consec++;
        end else begin
          consec = 0;
          cap_q.push_back({io_mgmt_address, io_mgmt_writedata});
          last_xfer = cyc;
          if (k == toggle_at && !toggled) begin
            io_pal  = ~io_pal;
            toggled = 1;
          end
        end
      end
      prev_stall = wr;
      pa = io_mgmt_address;
      pd = io_mgmt_writedata;
      io_mgmt_waitrequest = wr;
    end
    io_mgmt_waitrequest = 1'b0;
  endtask

  typedef struct {
    logic pal;
    int   stall_idx;
    int   stall_len;
    int   toggle_at;
    logic exp_cur;
    int   exp_xfers;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit   seen;
    logic model_cur;
    int   tg;
    logic t;

    vecs[0] = '{1'b1, -1, 0, -1, 1'b1, 6};   // plain PAL programming
    vecs[1] = '{1'b0,  2, 3, -1, 1'b0, 6};   // NTSC, index-2 write stalled 3 cycles
    vecs[2] = '{1'b1, -1, 0,  3, 1'b0, 12};  // PAL, switched back to NTSC at index 3
    vecs[3] = '{1'b1,  5, 2, -1, 1'b1, 6};   // PAL, start write stalled 2 cycles

    reset = 1'b1;
    io_pal = 1'b0;
    io_pll_locked = 1'b1;
    io_mgmt_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Matching standard after reset: the controller must stay quiet.
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (io_busy || io_tv_reset || io_mgmt_write) seen = 1;
    end
    chk("quiet_1000", 64'(seen), 64'd0);

    for (int v = 0; v < 4; v++) begin
      io_pal = vecs[v].pal;
      exp_q.delete();
      add_seq(vecs[v].pal);
      if (vecs[v].toggle_at >= 0) add_seq(~vecs[v].pal);
      run(vecs[v].stall_idx, vecs[v].stall_len, vecs[v].toggle_at, -1, 0);
      chk($sformatf("vec%0d_nxfer", v), 64'(cap_q.size()), 64'(vecs[v].exp_xfers));
      cmp_xfers($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_curpal", v), 64'(io_cur_pal), 64'(vecs[v].exp_cur));
      chk($sformatf("vec%0d_tvgap", v), 64'(gap_err), 64'd0);
      chk($sformatf("vec%0d_stable", v), 64'(stab_err), 64'd0);
      chk($sformatf("vec%0d_extend", v), 64'(fall_cyc - last_xfer), 64'(RE + 2));
      chk($sformatf("vec%0d_timeout", v), 64'(io_timeout), 64'd0);
      if (vecs[v].stall_idx >= 0)
        chk($sformatf("vec%0d_held", v), 64'(held_cyc), 64'(vecs[v].stall_len + 1));
      repeat (5) @(negedge clk);
    end

    // Lock never arrives: timeout flag, core released, back to idle.
    io_pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    io_pal = 1'b0;
    exp_q.delete();
    add_seq(1'b0);
    run(-1, 0, -1, -1, 0);
    cmp_xfers("tmo");
    chk("tmo_seen", 64'(to_seen), 64'd1);
    chk("tmo_time", 64'(to_cyc - last_xfer), 64'(RE + 1 + LT));
    chk("tmo_release_same_cycle", 64'(fall_cyc), 64'(to_cyc));
    chk("tmo_tvreset", 64'(io_tv_reset), 64'd0);
    chk("tmo_busy", 64'(io_busy), 64'd0);
    chk("tmo_curpal", 64'(io_cur_pal), 64'd0);
    io_pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    chk("tmo_sticky", 64'(io_timeout), 64'd1);

    // Glitch between clock edges never reaches the synchroniser output.
    @(negedge clk);
    #1 io_pal = 1'b1;
    #2 io_pal = 1'b0;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (io_busy || io_mgmt_write) seen = 1;
    end
    chk("glitch_ignored", 64'(seen), 64'd0);

    // Reset during the index-4 write, then a full PAL rerun.
    io_pal = 1'b1;
    run(-1, 0, -1, 4, 0);
    chk("rst_reached_idx4", 64'(rst_done), 64'd1);
    chk("rst_xfers_before", 64'(cap_q.size()), 64'd4);
    @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b0;
    exp_q.delete();
    add_seq(1'b1);
    run(-1, 0, -1, -1, 0);
    cmp_xfers("rerun");
    chk("rerun_curpal", 64'(io_cur_pal), 64'd1);
    chk("rerun_timeout", 64'(io_timeout), 64'd0);
    repeat (3) @(negedge clk);

    // Randomized stalls and mid-sequence switches.
    model_cur = 1'b1;
    for (int r = 0; r < 12; r++) begin
      t = ~model_cur;
      io_pal = t;
      tg = int'($urandom_range(0, 9));
      exp_q.delete();
      add_seq(t);
      if (tg < 6) add_seq(~t);
      else        model_cur = t;
      run(-1, 0, (tg < 6) ? tg : -1, -1, 1);
      cmp_xfers($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_curpal", r), 64'(io_cur_pal), 64'(model_cur));
      chk($sformatf("rnd%0d_tvgap", r), 64'(gap_err), 64'd0);
      chk($sformatf("rnd%0d_stable", r), 64'(stab_err), 64'd0);
      chk($sformatf("rnd%0d_extend", r), 64'(fall_cyc - last_xfer), 64'(RE + 2));
      repeat (int'($urandom_range(1, 6))) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
